// File: rtl/mux4way_rr_collector.sv
// 4-to-1 valid/ready collector with round-robin arbitration and a single registered output slot.
// out_sel reports the source channel so a downstream demux can route replies back.
module mux4way_rr_collector #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_c,
  input  logic [WIDTH-1:0] in_d,
  input  logic             valid_a,
  input  logic             valid_b,
  input  logic             valid_c,
  input  logic             valid_d,
  output logic             ready_a,
  output logic             ready_b,
  output logic             ready_c,
  output logic             ready_d,
  output logic [WIDTH-1:0] out,
  output logic [1:0]       out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [WIDTH-1:0] out_q, out_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       last_grant_q, last_grant_d;

  logic [3:0]       valid_vec;
  logic [3:0]       ready_vec;
  logic [1:0]       winner;
  logic [1:0]       cand;
  logic             grant_found;
  logic             can_accept;
  logic             accept;
  logic [WIDTH-1:0] winner_data;

  assign valid_vec = {valid_d, valid_c, valid_b, valid_a};

  // Scan starts one past the last grant so the most recent winner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    winner      = last_grant_q;
    cand        = last_grant_q;
    for (int unsigned i = 1; i <= 4; i++) begin
      cand = last_grant_q + 2'(i);
      if (!grant_found && valid_vec[cand]) begin
        grant_found = 1'b1;
        winner      = cand;
      end
    end
  end

  always_comb begin
    winner_data = in_a;
    unique case (winner)
      2'd0: winner_data = in_a;
      2'd1: winner_data = in_b;
      2'd2: winner_data = in_c;
      2'd3: winner_data = in_d;
    endcase
  end

  // Gating with rst_n keeps every ready low while reset is asserted.
  assign can_accept = !out_valid_q || out_ready;
  assign accept     = rst_n && can_accept && grant_found;
  assign ready_vec  = accept ? (4'b0001 << winner) : 4'b0000;

  assign ready_a = ready_vec[0];
  assign ready_b = ready_vec[1];
  assign ready_c = ready_vec[2];
  assign ready_d = ready_vec[3];

  always_comb begin
    out_d        = out_q;
    out_sel_d    = out_sel_q;
    out_valid_d  = out_valid_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      out_d        = winner_data;
      out_sel_d    = winner;
      out_valid_d  = 1'b1;
      last_grant_d = winner;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q        <= '0;
      out_sel_q    <= 2'd0;
      out_valid_q  <= 1'b0;
      last_grant_q <= 2'd3;
    end else begin
      out_q        <= out_d;
      out_sel_q    <= out_sel_d;
      out_valid_q  <= out_valid_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign out       = out_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux4way_rr_collector.sv
// Randomized and directed bench for mux4way_rr_collector against a queue-free behavioural model
// of the round-robin collector (last grant, held word, occupancy).
module tb_mux4way_rr_collector;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] din[4];
  logic         vin[4];
  logic         out_ready;
  logic         ready_a, ready_b, ready_c, ready_d;
  logic [W-1:0] out;
  logic [1:0]   out_sel;
  logic         out_valid;
  logic [3:0]   ready_vec;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  int         m_last;
  logic [W-1:0] m_out;
  logic [1:0] m_sel;
  logic       m_valid;

  always #5 clk = ~clk;

  assign ready_vec = {ready_d, ready_c, ready_b, ready_a};

  mux4way_rr_collector #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_a     (din[0]),
    .in_b     (din[1]),
    .in_c     (din[2]),
    .in_d     (din[3]),
    .valid_a  (vin[0]),
    .valid_b  (vin[1]),
    .valid_c  (vin[2]),
    .valid_d  (vin[3]),
    .ready_a  (ready_a),
    .ready_b  (ready_b),
    .ready_c  (ready_c),
    .ready_d  (ready_d),
    .out      (out),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  function automatic int exp_winner();
    for (int k = 1; k <= 4; k++) begin
      int ch;
      ch = (m_last + k) % 4;
      if (vin[ch]) return ch;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready();
    int w;
    w = exp_winner();
    if (!rst_n || w < 0) return 4'b0000;
    if (m_valid && !out_ready) return 4'b0000;
    return 4'(1 << w);
  endfunction

  task automatic model_reset();
    m_last  = 3;
    m_out   = '0;
    m_sel   = 2'd0;
    m_valid = 1'b0;
  endtask

  // Advance one rising edge and update the model from the inputs present at that edge.
  task automatic tick();
    logic [3:0] r;
    int w;
    r = exp_ready();
    w = exp_winner();
    @(posedge clk);
    if (r != 4'b0000) begin
      m_out   = din[w];
      m_sel   = 2'(w);
      m_valid = 1'b1;
      m_last  = w;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic clear_inputs();
    for (int i = 0; i < 4; i++) begin
      vin[i] = 1'b0;
      din[i] = '0;
    end
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    vin[0] = 1'b1;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (ready_vec !== 4'b0000) begin
      miscompares++; $display("FAIL reset_ready: got %b want 0000", ready_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // Load a word, then stall it and reset asynchronously mid-cycle.
    clear_inputs();
    vin[0] = 1'b1; din[0] = 16'hABCD; out_ready = 1'b1;
    tick();
    vin[0] = 1'b0; out_ready = 1'b0;
    tick();
    vectors++;
    if (out_valid !== 1'b1 || out !== 16'hABCD) begin
      miscompares++; $display("FAIL reset_preload: got v=%b out=%h want v=1 out=abcd", out_valid, out);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out !== 16'h0000 || out_sel !== 2'd0 || ready_vec !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_async: got v=%b out=%h sel=%0d rdy=%b want 0/0000/0/0000",
               out_valid, out, out_sel, ready_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) vin[i] = 1'b1;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (ready_vec !== 4'b0001) begin
      miscompares++; $display("FAIL reset_restart_a: got %b want 0001", ready_vec);
    end
    tick();
  endtask

  task automatic test_single_source();
    do_reset();
    vin[2] = 1'b1; din[2] = 16'h1234; out_ready = 1'b1;
    #1;
    vectors++;
    if (ready_vec !== 4'b0100) begin
      miscompares++; $display("FAIL single_ready: got %b want 0100", ready_vec);
    end
    tick();
    vin[2] = 1'b0;
    vectors++;
    if (out !== 16'h1234 || out_sel !== 2'd2 || out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL single_out: got out=%h sel=%0d v=%b want 1234/2/1", out, out_sel, out_valid);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      vin[i] = 1'b1;
      din[i] = 16'(i + 1);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      vectors++;
      if (ready_vec !== 4'(1 << (i % 4))) begin
        miscompares++; $display("FAIL rr_ready[%0d]: got %b want %b", i, ready_vec, 4'(1 << (i % 4)));
      end
      tick();
      vectors++;
      if (out_sel !== 2'(i % 4) || out !== 16'(i % 4 + 1) || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL rr_out[%0d]: got sel=%0d out=%h v=%b want %0d/%h/1",
                 i, out_sel, out, out_valid, i % 4, 16'(i % 4 + 1));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      vin[i] = 1'b1;
      din[i] = 16'($urandom);
    end
    out_ready = 1'b1;
    tick();
    tick();
    held = din[1];
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++;
      if (ready_vec !== 4'b0000) begin
        miscompares++; $display("FAIL bp_ready[%0d]: got %b want 0000", i, ready_vec);
      end
      tick();
      vectors++;
      if (out !== held || out_sel !== 2'd1 || out_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_hold[%0d]: got out=%h sel=%0d v=%b want %h/1/1", i, out, out_sel, out_valid, held);
      end
    end
    out_ready = 1'b1;
    #1;
    vectors++;
    if (ready_vec !== 4'b0100) begin
      miscompares++; $display("FAIL bp_release_ready: got %b want 0100", ready_vec);
    end
    tick();
    vectors++;
    if (out_sel !== 2'd2 || out !== din[2]) begin
      miscompares++; $display("FAIL bp_release_out: got sel=%0d out=%h want 2/%h", out_sel, out, din[2]);
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    vin[1] = 1'b1; din[1] = 16'h0B0B; out_ready = 1'b1;
    #1;
    vectors++;
    if (ready_vec !== 4'b0010) begin
      miscompares++; $display("FAIL wrap_b_ready: got %b want 0010", ready_vec);
    end
    tick();
    vectors++;
    if (out_sel !== 2'd1 || out !== 16'h0B0B) begin
      miscompares++; $display("FAIL wrap_b_out: got sel=%0d out=%h want 1/0b0b", out_sel, out);
    end
    vin[0] = 1'b1; din[0] = 16'h0A0A;
    #1;
    vectors++;
    if (ready_vec !== 4'b0001) begin
      miscompares++; $display("FAIL wrap_a_ready: got %b want 0001", ready_vec);
    end
    tick();
    vectors++;
    if (out_sel !== 2'd0 || out !== 16'h0A0A) begin
      miscompares++; $display("FAIL wrap_a_out: got sel=%0d out=%h want 0/0a0a", out_sel, out);
    end
  endtask

  task automatic test_drain();
    logic [W-1:0] prev;
    prev = out;
    for (int i = 0; i < 4; i++) vin[i] = 1'b0;
    out_ready = 1'b1;
    #1;
    vectors++;
    if (ready_vec !== 4'b0000 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL drain_pre: got rdy=%b v=%b want 0000/1", ready_vec, out_valid);
    end
    tick();
    vectors++;
    if (out_valid !== 1'b0 || out !== prev || out_sel !== 2'd0) begin
      miscompares++;
      $display("FAIL drain_out: got v=%b out=%h sel=%0d want 0/%h/0", out_valid, out, out_sel, prev);
    end
  endtask

  task automatic test_random();
    logic held[4];
    do_reset();
    for (int i = 0; i < 4; i++) held[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!held[i]) begin
          vin[i] = ($urandom_range(0, 2) != 0);
          din[i] = 16'($urandom);
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      vectors++;
      if (ready_vec !== exp_ready()) begin
        miscompares++; $display("FAIL rand_ready[%0d]: got %b want %b", c, ready_vec, exp_ready());
      end
      for (int i = 0; i < 4; i++) held[i] = vin[i] && !ready_vec[i];
      tick();
      vectors++;
      if (out_valid !== m_valid || out !== m_out || out_sel !== m_sel) begin
        miscompares++;
        $display("FAIL rand_out[%0d]: got v=%b out=%h sel=%0d want %b/%h/%0d",
                 c, out_valid, out, out_sel, m_valid, m_out, m_sel);
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    model_reset();
    #2;
    test_reset();
    test_single_source();
    test_round_robin();
    test_backpressure();
    test_wrap_skip();
    test_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
